isp_restart_sequencer: RTL and testbench
========================================

# isp_restart_sequencer

Fabric-side controller that sequences the device restart after an in-system programming (ISP) session on the SmartFusion2 design. It accepts a restart request from firmware, waits for the MSS/MMUART traffic to go quiet, asserts a fabric quiesce window, then drives the system-controller restart service request with a ready/ack handshake. It reports the outcome to firmware. It sits beside the MSS subsystem instance, clocked from the fabric CCC GL0 and reset by the MSS power-on reset.

## Interface
- QUIET_CYCLES, 1024: consecutive idle cycles of `mss_busy_i` required before quiescing (≥1).
- HOLD_CYCLES, 256: length of the quiesce window before the service request (≥1).
- ACK_TIMEOUT, 65536: maximum cycles to wait for `svc_ack_i` (≥1).

- CLK  in  1  fabric clock (FAB_CCC_GL0); single clock domain.
- RESETn  in  1  reset; synchronous, active-low.
- start_i  in  1  restart request; sampled every cycle, accepted only in IDLE.
- abort_i  in  1  cancel; honoured only in QUIET and HOLD.
- mss_busy_i  in  1  MSS/MMUART activity indicator; synchronous to CLK.
- svc_ack_i  in  1  system-controller acknowledge; honoured only in ISSUE.
- svc_req_o  out  1  restart service request; high for all of ISSUE.
- quiesce_o  out  1  stop request to fabric logic; high in HOLD and ISSUE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  2  outcome: 0 OK, 1 ABORTED, 2 TIMEOUT, 3 reserved/never driven.

## Operation
- Moore FSM with states IDLE, QUIET, HOLD, ISSUE, FINISH. All outputs are registered decodes of the state and status registers.
- A single down-counter is loaded with N-1 on entry to a timed state. With no disturbance, that state lasts exactly N cycles.
- IDLE: on `start_i`, go to QUIET, load QUIET_CYCLES-1, and clear `status_o` to 0.
- QUIET: while `mss_busy_i`=1, reload QUIET_CYCLES-1. Otherwise decrement. When the counter is 0 and `mss_busy_i` is 0, go to HOLD and load HOLD_CYCLES-1. On `abort_i`, go to FINISH with ABORTED.
- HOLD: decrement; at 0 go to ISSUE and load ACK_TIMEOUT-1. `mss_busy_i` is ignored. On `abort_i`, go to FINISH with ABORTED.
- ISSUE: `svc_req_o` is held high until an outcome. On `svc_ack_i`, go to FINISH with OK. If the counter is 0 with no ack, go to FINISH with TIMEOUT (see Configuration). `abort_i` is ignored.
- FINISH: `done_o`=1 for one cycle, `quiesce_o`/`svc_req_o` are low, then return to IDLE. `status_o` holds until the next accepted start.
- Counter width is $clog2 of the largest parameter plus 1. Decrement never wraps below 0.

## Timing
- Reset value of all outputs is 0 (`status_o`=0); state is IDLE.
- Reset asserted in any state, including ISSUE, drops `svc_req_o` and `quiesce_o` on the next edge. No FINISH pulse is generated.
- `start_i` accepted at edge 0 gives QUIET in cycles 1..QUIET_CYCLES when not busy. HOLD follows for HOLD_CYCLES, then ISSUE.
- FINISH occurs the cycle after the deciding event. `done_o` and the new `status_o` are valid in the same cycle.
- Simultaneous events:
  - `abort_i` wins over counter expiry.
  - `svc_ack_i` wins over timeout.
  - `start_i` together with `abort_i` in IDLE: start is accepted and abort is ignored.
  - `start_i` outside IDLE is ignored.

## Configuration
- ISP_RESTART_WATCHDOG_EN defined: the ISSUE timeout is active and yields TIMEOUT as above.
- Not defined: ISSUE waits indefinitely for `svc_ack_i`. The counter is not loaded in ISSUE, and status 2 is never produced.

## Structure
- Shared package `isp_restart_pkg` holds:
  - the state enum (`isp_rst_state_t`);
  - the status codes (`ISP_RST_OK`, `ISP_RST_ABORTED`, `ISP_RST_TIMEOUT`);
  - the default parameter constants.
- One sub-module, `isp_restart_timer`, provides the loadable saturating down-counter with a zero flag. The FSM, status register and output decode stay in the top module.

## Test plan
All scenarios use QUIET_CYCLES=8, HOLD_CYCLES=4, ACK_TIMEOUT=16.

- Nominal: `start_i` at cycle 0, `mss_busy_i`=0, `svc_ack_i` at cycle 15 → `quiesce_o` high cycles 9..15, `svc_req_o` high 13..15, `done_o` at 16, `status_o`=0, `busy_o` low at 17.
- Busy restart: `mss_busy_i` high in cycle 5 → HOLD entry slips to cycle 14, and all later events slip by 5.
- Abort: `abort_i` at cycle 10 (HOLD) → `done_o` at 11, `status_o`=1, `svc_req_o` never asserted. `abort_i` in ISSUE has no effect.
- Timeout with the macro defined: no ack → `svc_req_o` high 13..28, `done_o` at 29, `status_o`=2. Ack and expiry together in cycle 28 → `status_o`=0.
- Reset and ignore rules: RESETn low at cycle 14 → all outputs 0 from cycle 15. After reset release, a `start_i` pulse while busy is ignored. Without the macro, `svc_req_o` stays high past cycle 100.

Source files
------------

// File: rtl/isp_restart_sequencer_pkg.sv
// Shared types and defaults for the post-ISP restart sequencer.
package isp_restart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIET,
        ST_HOLD,
        ST_ISSUE,
        ST_FINISH
    } isp_rst_state_t;

    typedef logic [1:0] isp_rst_status_t;

    localparam isp_rst_status_t ISP_RST_OK      = 2'd0;
    localparam isp_rst_status_t ISP_RST_ABORTED = 2'd1;
    localparam isp_rst_status_t ISP_RST_TIMEOUT = 2'd2;

    localparam int unsigned ISP_RST_QUIET_CYCLES = 1024;
    localparam int unsigned ISP_RST_HOLD_CYCLES  = 256;
    localparam int unsigned ISP_RST_ACK_TIMEOUT  = 65536;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/isp_restart_sequencer_if.sv
// Firmware / MSS / system-controller signal bundle of the restart sequencer.
interface isp_restart_sequencer_if;
    logic       start_i;
    logic       abort_i;
    logic       mss_busy_i;
    logic       svc_ack_i;
    logic       svc_req_o;
    logic       quiesce_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] status_o;

    modport master (
        output start_i, abort_i, mss_busy_i, svc_ack_i,
        input  svc_req_o, quiesce_o, busy_o, done_o, status_o
    );

    modport slave (
        input  start_i, abort_i, mss_busy_i, svc_ack_i,
        output svc_req_o, quiesce_o, busy_o, done_o, status_o
    );
endinterface

// File: rtl/isp_restart_sequencer_timer.sv
// Loadable down-counter that saturates at zero and flags it.
module isp_restart_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/isp_restart_sequencer.sv
// Restart sequencer: wait for MSS quiet, quiesce fabric, request restart service.
// Optional ISSUE watchdog enabled by defining ISP_RESTART_WATCHDOG_EN.
module isp_restart_sequencer
    import isp_restart_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = ISP_RST_QUIET_CYCLES,
    parameter int unsigned HOLD_CYCLES  = ISP_RST_HOLD_CYCLES,
    parameter int unsigned ACK_TIMEOUT  = ISP_RST_ACK_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    isp_restart_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(max3(QUIET_CYCLES, HOLD_CYCLES, ACK_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] QUIET_LD = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
`ifdef ISP_RESTART_WATCHDOG_EN
    localparam logic [CNT_W-1:0] ACK_LD   = CNT_W'(ACK_TIMEOUT - 1);
`endif

    isp_rst_state_t   state, state_nxt;
    isp_rst_status_t  status, status_nxt;
    logic             load, dec, zero;
    logic [CNT_W-1:0] load_val;
    logic             svc_req, quiesce, busy, done;

    isp_restart_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst_n    (RESETn),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // Abort is checked before expiry, ack before timeout.
    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        load       = 1'b0;
        load_val   = QUIET_LD;
        dec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_nxt  = ST_QUIET;
                    status_nxt = ISP_RST_OK;
                    load       = 1'b1;
                    load_val   = QUIET_LD;
                end
            end
            ST_QUIET: begin
                if (bus.abort_i) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = ISP_RST_ABORTED;
                end else if (bus.mss_busy_i) begin
                    load     = 1'b1;
                    load_val = QUIET_LD;
                end else if (zero) begin
                    state_nxt = ST_HOLD;
                    load      = 1'b1;
                    load_val  = HOLD_LD;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.abort_i) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = ISP_RST_ABORTED;
                end else if (zero) begin
                    state_nxt = ST_ISSUE;
`ifdef ISP_RESTART_WATCHDOG_EN
                    load      = 1'b1;
                    load_val  = ACK_LD;
`endif
                end else begin
                    dec = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.svc_ack_i) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = ISP_RST_OK;
`ifdef ISP_RESTART_WATCHDOG_EN
                end else if (zero) begin
                    state_nxt  = ST_FINISH;
                    status_nxt = ISP_RST_TIMEOUT;
                end else begin
                    dec = 1'b1;
`endif
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= ST_IDLE;
            status  <= ISP_RST_OK;
            svc_req <= 1'b0;
            quiesce <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            status  <= status_nxt;
            svc_req <= (state_nxt == ST_ISSUE);
            quiesce <= (state_nxt == ST_HOLD) || (state_nxt == ST_ISSUE);
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_FINISH);
        end
    end

    assign bus.svc_req_o = svc_req;
    assign bus.quiesce_o = quiesce;
    assign bus.busy_o    = busy;
    assign bus.done_o    = done;
    assign bus.status_o  = status;
endmodule

// File: tb/tb_isp_restart_sequencer.sv
// Directed and random scenarios for isp_restart_sequencer against an event-time model.
module tb_isp_restart_sequencer;
    localparam int Q = 8, H = 4, T = 16, N = 256;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    isp_restart_sequencer_if bus();

    isp_restart_sequencer #(
        .QUIET_CYCLES (Q),
        .HOLD_CYCLES  (H),
        .ACK_TIMEOUT  (T)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    // Per-cycle input script; cycle 0 is the cycle whose closing edge samples the start.
    bit st[N], ab[N], bz[N], ak[N];
    // Model results: HOLD entry cycle, ISSUE entry cycle, FINISH cycle, outcome.
    int h, i_iss, f;
    logic [1:0] code;
    logic [1:0] prev_status = 2'd0;

    task automatic check(input string tag, input int c, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.svc_req_o, bus.quiesce_o, bus.busy_o, bus.done_o, bus.status_o};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed req/qui/bsy/dn/st=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic clear_script();
        for (int c = 0; c < N; c++) begin
            st[c] = 0; ab[c] = 0; bz[c] = 0; ak[c] = 0;
        end
        st[0] = 1;
    endtask

    // Event timeline from the rules: QUIET needs Q idle cycles after the last busy one,
    // HOLD is H cycles, first abort before ISSUE ends it, first ack in ISSUE completes it.
    task automatic model();
        int b;
        int k;
        b = 0;
        h = -1;
        for (int c = 1; c < N; c++) begin
            if (bz[c]) b = c;
            else if (c == b + Q) begin
                h = c + 1;
                break;
            end
        end
        i_iss = h + H;
        f = -1;
        for (int c = 1; c < i_iss; c++)
            if (ab[c]) begin
                f = c + 1;
                code = 2'd1;
                break;
            end
        if (f < 0) begin
            k = -1;
            for (int c = i_iss; c < N - 2; c++)
                if (ak[c]) begin
                    k = c;
                    break;
                end
`ifdef ISP_RESTART_WATCHDOG_EN
            if (k >= 0 && k < i_iss + T) begin
                f = k + 1; code = 2'd0;
            end else begin
                f = i_iss + T; code = 2'd2;
            end
`else
            f = k + 1;
            code = 2'd0;
`endif
        end
        for (int c = f + 1; c < N; c++) st[c] = 0;
    endtask

    function automatic logic [5:0] expect_at(input int c);
        logic sr, qs, bs, dn;
        logic [1:0] s;
        if (c == 0) return {4'b0000, prev_status};
        sr = (c >= i_iss) && (c < f);
        qs = (c >= h) && (c < f);
        bs = (c <= f);
        dn = (c == f);
        s  = (c < f) ? 2'd0 : code;
        return {sr, qs, bs, dn, s};
    endfunction

    task automatic run(input string tag, input int rst_at);
        model();
        for (int c = 0; c <= f + 1; c++) begin
            bus.start_i    = st[c];
            bus.abort_i    = ab[c];
            bus.mss_busy_i = bz[c];
            bus.svc_ack_i  = ak[c];
            RESETn         = (c != rst_at);
            @(negedge CLK);
            check(tag, c, expect_at(c));
            @(posedge CLK);
            #1;
            if (c == rst_at) begin
                RESETn = 1'b1;
                bus.start_i = 0; bus.abort_i = 0; bus.mss_busy_i = 0; bus.svc_ack_i = 0;
                @(negedge CLK);
                check({tag, "_post_reset"}, c + 1, 6'b000000);
                @(posedge CLK);
                #1;
                prev_status = 2'd0;
                return;
            end
        end
        prev_status = code;
    endtask

    initial begin
        bus.start_i = 0; bus.abort_i = 0; bus.mss_busy_i = 0; bus.svc_ack_i = 0;
        RESETn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("reset", c, 6'b000000);
        end
        @(posedge CLK);
        #1;
        RESETn = 1'b1;

        clear_script(); ak[15] = 1;              run("nominal", -1);
        clear_script(); bz[5] = 1; ak[20] = 1;   run("busy_slip", -1);
        clear_script(); ab[10] = 1; ak[15] = 1;  run("abort_hold", -1);
        clear_script(); ab[14] = 1; ak[15] = 1;  run("abort_issue_ignored", -1);
        clear_script(); ab[8] = 1;               run("abort_at_quiet_expiry", -1);
        clear_script(); ab[0] = 1; ak[13] = 1;   run("start_with_abort", -1);
        clear_script(); st[3] = 1; st[10] = 1; st[16] = 1; ak[15] = 1;
        run("start_ignored_when_busy", -1);
`ifdef ISP_RESTART_WATCHDOG_EN
        clear_script();                          run("timeout", -1);
        clear_script(); ak[28] = 1;              run("ack_at_expiry", -1);
`else
        clear_script(); ak[120] = 1;             run("no_watchdog_wait", -1);
`endif
        clear_script(); ak[15] = 1;              run("reset_in_issue", 14);
        clear_script(); st[4] = 1; ak[15] = 1;   run("after_reset", -1);

        for (int n = 0; n < 40; n++) begin
            clear_script();
            for (int c = 1; c < N; c++) begin
                st[c] = ($urandom % 4) == 0;
                bz[c] = (c <= 30) && (($urandom % 8) == 0);
                ab[c] = ($urandom % 40) == 0;
                ak[c] = ($urandom % 12) == 0;
            end
            ak[100] = 1;
            run("random", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
